// File: rtl/gray_checker.sv
// gray_checker: receive-side monitor for a Gray-coded counter stream.
// Decodes each sample to binary and accepts it only if it holds the previous
// value or steps forward by one (modulo 2^WIDTH). Wraps are counted. Any other
// sample is latched as a sticky fault until ClearErr.
//
// Parameters
//   WIDTH      Gray code / binary width
//   CNT_W      width of the saturating wrap and error counters
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high
//   Valid      GrayIn/OverflowIn are sampled on this edge
//   GrayIn     Gray-coded count from the producer
//   OverflowIn producer overflow flag, sampled with GrayIn
//   ClearErr   single-cycle pulse: return to IDLE (leaves FAULT, re-arms)
//   BinOut     registered binary value of the last accepted sample
//   Locked     high while tracking
//   Error      high while in FAULT
//   WrapCnt    saturating count of max->0 wraps
//   ErrCnt     saturating count of FAULT entries (cleared only by Reset)
// Configuration
//   GRAY_CHECK_OVERFLOW_EN  when defined, OverflowIn must be 1 exactly on a
//                           wrap step and 0 on every other accepted sample in
//                           TRACK; a mismatch is a fault. When undefined the
//                           flag is ignored.
module gray_checker #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             OverflowIn,
    input  logic             ClearErr,
    output logic [WIDTH-1:0] BinOut,
    output logic             Locked,
    output logic             Error,
    output logic [CNT_W-1:0] WrapCnt,
    output logic [CNT_W-1:0] ErrCnt
);

    localparam int unsigned BW = WIDTH;
    localparam int unsigned CW = CNT_W;
    localparam logic [BW-1:0] BIN_MAX = {BW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] prev_q,  prev_d;
    logic [BW-1:0] bin_d;
    logic          locked_d;
    logic          error_d;
    logic [CW-1:0] wrap_d;
    logic [CW-1:0] errc_d;

    logic [BW-1:0] decoded;
    logic [BW-1:0] prev_inc;
    logic          is_hold;
    logic          is_step;
    logic          is_wrap;
    logic          accept;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [BW-1:0] gray2bin(input logic [BW-1:0] g);
        logic [BW-1:0] b;
        b = '0;
        b[BW-1] = g[BW-1];
        for (int i = int'(BW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + CW'(1);
    endfunction

    // Sample classification against the last accepted value.
    always_comb begin
        decoded  = gray2bin(GrayIn);
        prev_inc = prev_q + BW'(1);
        is_hold  = (decoded == prev_q);
        is_step  = (decoded == prev_inc);
        is_wrap  = is_step && (prev_q == BIN_MAX);
    end

`ifdef GRAY_CHECK_OVERFLOW_EN
    // The producer flag must agree with our own wrap detection.
    logic ovf_ok;
    assign ovf_ok = (OverflowIn == is_wrap);
    assign accept = (is_hold || is_step) && ovf_ok;
`else
    // Port kept for interface stability; intentionally not observed.
    logic unused_ovf;
    assign unused_ovf = OverflowIn;
    assign accept     = is_hold || is_step;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = BinOut;
        wrap_d  = WrapCnt;
        errc_d  = ErrCnt;

        if (ClearErr) begin
            // A sample coinciding with the clear is discarded.
            state_d = ST_IDLE;
        end else if (Valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    // First sample after reset/clear is taken without a step check.
                    prev_d  = decoded;
                    bin_d   = decoded;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (accept) begin
                        prev_d = decoded;
                        bin_d  = decoded;
                        if (is_wrap) begin
                            wrap_d = sat_inc(WrapCnt);
                        end
                    end else begin
                        state_d = ST_FAULT;
                        errc_d  = sat_inc(ErrCnt);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_TRACK);
        error_d  = (state_d == ST_FAULT);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            BinOut  <= '0;
            Locked  <= 1'b0;
            Error   <= 1'b0;
            WrapCnt <= '0;
            ErrCnt  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            BinOut  <= bin_d;
            Locked  <= locked_d;
            Error   <= error_d;
            WrapCnt <= wrap_d;
            ErrCnt  <= errc_d;
        end
    end

endmodule

// File: tb/tb_gray_checker.sv
// Self-checking bench for gray_checker (WIDTH=3, CNT_W=8).
// Each driven cycle pushes the reference model's expected outputs to a queue;
// after the clock edge the entry is popped and compared with the DUT.
module tb_gray_checker;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [WIDTH-1:0] gin;
    logic             ovf;
    logic             clr;
    logic [WIDTH-1:0] bin_out;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    gray_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Valid      (valid),
        .GrayIn     (gin),
        .OverflowIn (ovf),
        .ClearErr   (clr),
        .BinOut     (bin_out),
        .Locked     (locked),
        .Error      (error),
        .WrapCnt    (wrap_cnt),
        .ErrCnt     (err_cnt)
    );

    typedef struct {
        int bin;
        int lck;
        int err;
        int wrap;
        int errc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model state: 0 idle, 1 track, 2 fault.
    int m_state = 0;
    int m_prev  = 0;
    int m_bin   = 0;
    int m_wrap  = 0;
    int m_errc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Binary value whose Gray encoding equals g (search, not an XOR chain).
    function automatic int model_decode(input int g);
        for (int x = 0; x < 8; x++) begin
            if ((x ^ (x >> 1)) == g) return x;
        end
        return 0;
    endfunction

    task automatic model_step(input bit r, input bit v, input int g, input bit o, input bit c);
        int  d;
        bit  ok;
        bit  wr;
        if (r) begin
            m_state = 0; m_prev = 0; m_bin = 0; m_wrap = 0; m_errc = 0;
        end else if (c) begin
            m_state = 0;
        end else if (v) begin
            d = model_decode(g);
            if (m_state == 0) begin
                m_prev = d; m_bin = d; m_state = 1;
            end else if (m_state == 1) begin
                wr = (d == ((m_prev + 1) % 8)) && (m_prev == 7);
                ok = (d == m_prev) || (d == ((m_prev + 1) % 8));
`ifdef GRAY_CHECK_OVERFLOW_EN
                if (ok && (o != wr)) ok = 1'b0;
`endif
                if (ok) begin
                    m_prev = d; m_bin = d;
                    if (wr && m_wrap < 255) m_wrap++;
                end else begin
                    m_state = 2;
                    if (m_errc < 255) m_errc++;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int g, input bit o, input bit c);
        exp_t e;
        rst = r; valid = v; gin = 3'(g); ovf = o; clr = c;
        model_step(r, v, g, o, c);
        e.bin = m_bin; e.lck = (m_state == 1); e.err = (m_state == 2);
        e.wrap = m_wrap; e.errc = m_errc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("bin",    32'(bin_out),  32'(e.bin));
        check("locked", 32'(locked),   32'(e.lck));
        check("error",  32'(error),    32'(e.err));
        check("wrap",   32'(wrap_cnt), 32'(e.wrap));
        check("errcnt", 32'(err_cnt),  32'(e.errc));
    endtask

    task automatic sendg(input int g, input bit o = 1'b0);
        cycle(1'b0, 1'b1, g, o, 1'b0);
    endtask

    task automatic send(input int b, input bit o = 1'b0);
        cycle(1'b0, 1'b1, b ^ (b >> 1), o, 1'b0);
    endtask

    task automatic clear(input bit v = 1'b0, input int g = 0);
        cycle(1'b0, v, g, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] seq1 [9];
        int pick;
        int nb;
        bit o;
        seq1 = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        rst = 1'b1; valid = 1'b0; gin = '0; ovf = 1'b0; clr = 1'b0;

        // Reset state
        do_reset();
        check("rst_bin", 32'(bin_out), 0);
        check("rst_locked", 32'(locked), 0);
        idle();

        // 1: full count with one wrap
        for (int i = 0; i < 9; i++) begin
            sendg(int'(seq1[i]), i == 8);
            check("tp1_bin", 32'(bin_out), 32'(i % 8));
        end
        check("tp1_wrap", 32'(wrap_cnt), 1);
        check("tp1_locked", 32'(locked), 1);

        // 2: skip faults, samples ignored, clear re-arms
        sendg(3'b001);
        sendg(3'b010);
        check("tp2_err", 32'(error), 1);
        check("tp2_errcnt", 32'(err_cnt), 1);
        check("tp2_bin", 32'(bin_out), 1);
        sendg(3'b110);
        check("tp2_ignored", 32'(bin_out), 1);
        clear();
        check("tp2_cleared", 32'(error), 0);
        sendg(3'b110);
        check("tp2_relock", 32'(bin_out), 4);
        check("tp2_locked", 32'(locked), 1);

        // 3: holds then one step, then a backward step
        clear();
        for (int i = 0; i < 5; i++) sendg(3'b011);
        check("tp3_hold", 32'(bin_out), 2);
        sendg(3'b010);
        sendg(3'b010);
        check("tp3_step", 32'(bin_out), 3);
        check("tp3_noerr", 32'(error), 0);
        sendg(3'b001);
        check("tp3_back", 32'(error), 1);

        // 4: reset mid-stream at BinOut=5, WrapCnt=2
        do_reset();
        send(0);
        for (int k = 1; k <= 16; k++) send(k % 8, (k % 8) == 0);
        for (int k = 1; k <= 5; k++) send(k);
        check("tp4_pre_bin", 32'(bin_out), 5);
        check("tp4_pre_wrap", 32'(wrap_cnt), 2);
        do_reset();
        check("tp4_rst_wrap", 32'(wrap_cnt), 0);
        check("tp4_rst_bin", 32'(bin_out), 0);
        sendg(3'b111);
        check("tp4_first", 32'(bin_out), 5);
        check("tp4_nofault", 32'(error), 0);

        // 5: clear and valid together in FAULT discards the sample
        sendg(3'b000);
        clear(1'b1, 0);
        check("tp5_bin", 32'(bin_out), 5);
        check("tp5_locked", 32'(locked), 0);
        check("tp5_err", 32'(error), 0);
        idle();

        // 6: overflow flag on wrap
        send(7);
        sendg(3'b000, 1'b0);
`ifdef GRAY_CHECK_OVERFLOW_EN
        check("tp6_ovf0_err", 32'(error), 1);
        check("tp6_ovf0_wrap", 32'(wrap_cnt), 0);
`else
        check("tp6_ovf0_err", 32'(error), 0);
        check("tp6_ovf0_wrap", 32'(wrap_cnt), 1);
`endif
        clear();
        send(7);
        sendg(3'b000, 1'b1);
        check("tp6_ovf1_err", 32'(error), 0);
`ifdef GRAY_CHECK_OVERFLOW_EN
        check("tp6_ovf1_wrap", 32'(wrap_cnt), 1);
`else
        check("tp6_ovf1_wrap", 32'(wrap_cnt), 2);
`endif
        send(1, 1'b1);
`ifdef GRAY_CHECK_OVERFLOW_EN
        check("tp6_spurious", 32'(error), 1);
`else
        check("tp6_spurious", 32'(error), 0);
`endif

        // Counter saturation
        do_reset();
        send(0);
        for (int k = 1; k <= 8 * 260; k++) send(k % 8, (k % 8) == 0);
        check("sat_wrap", 32'(wrap_cnt), 255);
        for (int k = 0; k < 260; k++) begin
            send(3);
            clear();
            send(0);
        end
        check("sat_errcnt", 32'(err_cnt), 255);
        check("sat_wrap_kept", 32'(wrap_cnt), 255);

        // Random traffic biased toward legal steps
        do_reset();
        for (int k = 0; k < 400; k++) begin
            nb = (m_prev + 1) % 8;
            pick = $urandom_range(0, 9);
            if (pick < 6)      pick = nb;
            else if (pick < 8) pick = m_prev;
            else               pick = $urandom_range(0, 7);
            o = (pick == nb) && (m_prev == 7);
            if ($urandom_range(0, 9) == 0) o = !o;
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  pick ^ (pick >> 1), o, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
